sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 86 ++++++++
 tb/tb_sync_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, watermark compare and
// sticky overflow/underflow flags. Storage is not reset; pointers and count are.
module sync_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [CW-1:0]        watermark_level,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 less_than_watermark,
  output logic                 greater_than_watermark,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 overflow_q;
  logic                 underflow_q;
  logic                 wr_acc;
  logic                 rd_acc;

  // Handshake: wr_en/rd_en are request strobes sampled on the rising edge.
  // A request takes effect only when its *_acc term is high; a write to a full
  // FIFO is allowed when a read frees the slot in the same cycle. Rejected
  // requests leave data and pointers alone and raise the matching sticky flag.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  assign count                  = count_q;
  assign overflow               = overflow_q;
  assign underflow              = underflow_q;
  assign rd_data                = empty ? '0 : mem[rd_ptr];
  assign greater_than_watermark = (count_q > watermark_level);
  assign less_than_watermark    = (count_q < watermark_level);

  always_ff @(posedge clock) begin
    if (wr_acc && !reset && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && full && !rd_en) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus pushes expected pop data into exp_q,
// a negedge monitor pops and compares whenever a read is being accepted.
module tb_sync_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [CW-1:0] watermark_level;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          less_than_watermark;
  logic          greater_than_watermark;
  logic          overflow;
  logic          underflow;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;
  int            vectors     = 0;
  int            miscompares = 0;

  sync_fifo #(.DATA_SIZE(W), .DEPTH(D)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush                 (flush),
    .wr_en                 (wr_en),
    .wr_data               (wr_data),
    .rd_en                 (rd_en),
    .watermark_level       (watermark_level),
    .rd_data               (rd_data),
    .count                 (count),
    .empty                 (empty),
    .full                  (full),
    .less_than_watermark   (less_than_watermark),
    .greater_than_watermark(greater_than_watermark),
    .overflow              (overflow),
    .underflow             (underflow)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: a read is accepted on the next edge, so rd_data now is the popped word
  always @(negedge clock) begin
    if (!reset && !flush && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got %0h, expected no pop", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", rd_data, mon_exp);
      end
    end
  end

  // driver tasks: inputs change #1 after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d);
    wr_en = 1'b1; wr_data = d; tick();
  endtask

  task automatic rd(input logic [W-1:0] exp);
    exp_q.push_back(exp); rd_en = 1'b1; tick();
  endtask

  task automatic rd_nopop();
    rd_en = 1'b1; tick();
  endtask

  task automatic rdwr(input logic [W-1:0] d, input bit pops, input logic [W-1:0] exp);
    if (pops) exp_q.push_back(exp);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = d; tick();
  endtask

  task automatic do_flush();
    flush = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_data = '0; watermark_level = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    tick();

    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_less_wm", less_than_watermark, 0);
    chk("rst_greater_wm", greater_than_watermark, 0);

    // fill and overflow
    for (int i = 0; i < 8; i++) wr(32'h10 + i);
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_head", rd_data, 32'h10);
    chk("fill_greater_wm", greater_than_watermark, 1);
    wr(32'h99);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_head", rd_data, 32'h10);

    // drain and underflow
    for (int i = 0; i < 8; i++) rd(32'h10 + i);
    chk("drain_empty", empty, 1);
    chk("drain_rd_data", rd_data, 0);
    chk("drain_count", count, 0);
    rd_nopop();
    chk("udf_flag", underflow, 1);
    chk("udf_overflow_sticky", overflow, 1);
    chk("udf_count", count, 0);
    do_flush();
    chk("flush_clr_ovf", overflow, 0);
    chk("flush_clr_udf", underflow, 0);

    // wrap-around
    for (int i = 0; i < 6; i++) wr(32'h20 + i);
    for (int i = 0; i < 6; i++) rd(32'h20 + i);
    for (int i = 0; i < 5; i++) wr(32'hA0 + i);
    chk("wrap_count5", count, 5);
    chk("wrap_head", rd_data, 32'hA0);
    for (int i = 0; i < 5; i++) rd(32'hA0 + i);
    chk("wrap_count0", count, 0);
    chk("wrap_empty", empty, 1);

    // simultaneous access when full
    for (int i = 0; i < 8; i++) wr(32'h30 + i);
    rdwr(32'h55, 1'b1, 32'h30);
    chk("simfull_count", count, 8);
    chk("simfull_full", full, 1);
    chk("simfull_head", rd_data, 32'h31);
    chk("simfull_no_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) rd(32'h30 + i);
    rd(32'h55);
    chk("simfull_drained", empty, 1);

    // simultaneous access when empty
    rdwr(32'h66, 1'b0, '0);
    chk("simempty_count", count, 1);
    chk("simempty_udf", underflow, 1);
    chk("simempty_head", rd_data, 32'h66);
    rd(32'h66);
    do_flush();

    // watermark
    watermark_level = 4'd3;
    wr(32'h40); wr(32'h41);
    chk("wm2_less", less_than_watermark, 1);
    chk("wm2_greater", greater_than_watermark, 0);
    wr(32'h42);
    chk("wm3_less", less_than_watermark, 0);
    chk("wm3_greater", greater_than_watermark, 0);
    wr(32'h43);
    chk("wm4_less", less_than_watermark, 0);
    chk("wm4_greater", greater_than_watermark, 1);

    // flush mid-operation with count 5 and overflow set
    for (int i = 4; i < 8; i++) wr(32'h40 + i);
    wr(32'h77);
    for (int i = 0; i < 3; i++) rd(32'h40 + i);
    chk("preflush_count", count, 5);
    chk("preflush_ovf", overflow, 1);
    wr_en = 1'b1; wr_data = 32'hEE; flush = 1'b1; tick();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_rd_data", rd_data, 0);

    // reset together with flush
    rd_nopop();
    wr(32'h50); wr(32'h51); wr(32'h52);
    chk("prereset_udf", underflow, 1);
    reset = 1'b1; flush = 1'b1; wr_en = 1'b1; wr_data = 32'hEF; tick();
    chk("rstflush_count", count, 0);
    chk("rstflush_empty", empty, 1);
    chk("rstflush_udf", underflow, 0);
    chk("rstflush_rd_data", rd_data, 0);
    wr(32'h88);
    chk("post_rst_head", rd_data, 32'h88);
    rd(32'h88);
    chk("post_rst_empty", empty, 1);

    tick(); tick();
    chk("exp_q_drained", W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
